// File: rtl/fg_config_loader.sv
// fg_config_loader
// Byte-serial loader for the function generator's configuration bus.
// Framed WRITE / COMMIT / ABORT / NOP commands arrive over a valid/ready
// byte stream. WRITE bytes are staged in a shadow register. A COMMIT copies
// the whole shadow to the active bus, optionally deferred to the generator's
// sample strobe so a waveform period is never reconfigured mid-sample.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active high
//   data_i         command/data byte
//   data_valid_i   data_i valid
//   data_ready_o   loader can accept a byte (combinational from state)
//   sample_strb_i  generator output-valid strobe
//   cr_bus_o       active configuration bus
//   cfg_update_o   one-cycle pulse: cr_bus_o just changed
//   busy_o         high when not idle (combinational from state)
//   error_o        sticky frame error, cleared by the next accepted header
module fg_config_loader #(
   parameter int unsigned                   CONFIG_REG_BITWIDTH = 56,
   parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_VALUE         = '0,
   parameter bit                            COMMIT_ON_STRB      = 1'b1,
   parameter int unsigned                   TIMEOUT_CYCLES      = 255
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [7:0]                     data_i,
   input  logic                           data_valid_i,
   output logic                           data_ready_o,
   input  logic                           sample_strb_i,
   output logic [CONFIG_REG_BITWIDTH-1:0] cr_bus_o,
   output logic                           cfg_update_o,
   output logic                           busy_o,
   output logic                           error_o
);

   localparam int unsigned NUM_BYTES = CONFIG_REG_BITWIDTH / 8;
   localparam int unsigned CNT_W     = 8;
   localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_COMMIT = 2'b10;
   localparam logic [1:0] OP_ABORT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_DROP,
      ST_COMMIT_WAIT
   } state_t;

   state_t                         state;
   logic [CONFIG_REG_BITWIDTH-1:0] shadow;
   logic [2:0]                     ptr;
   logic [3:0]                     remaining;
   logic [CNT_W-1:0]               to_cnt;

   logic       accept;
   logic [1:0] hdr_op;
   logic [2:0] hdr_index;
   logic [3:0] hdr_len;
   logic       hdr_fits;

   // Handshake and header decode
   assign data_ready_o = (state != ST_COMMIT_WAIT);
   assign busy_o       = (state != ST_IDLE);
   assign accept       = data_valid_i & data_ready_o;
   assign hdr_op       = data_i[7:6];
   assign hdr_index    = data_i[2:0];
   assign hdr_len      = 4'(data_i[5:3]) + 4'd1;
   // Max index+length is 7+8=15, so 4 bits cannot overflow
   assign hdr_fits     = (4'(hdr_index) + hdr_len) <= 4'(NUM_BYTES);

   // Loader FSM with shadow/active registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         shadow       <= RESET_VALUE;
         cr_bus_o     <= RESET_VALUE;
         cfg_update_o <= 1'b0;
         error_o      <= 1'b0;
         ptr          <= '0;
         remaining    <= '0;
         to_cnt       <= '0;
      end else begin
         cfg_update_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  error_o <= 1'b0;
                  to_cnt  <= '0;
                  case (hdr_op)
                     OP_WRITE: begin
                        remaining <= hdr_len;
                        if (hdr_fits) begin
                           ptr   <= hdr_index;
                           state <= ST_DATA;
                        end else begin
                           // Out-of-range frame: swallow its payload
                           error_o <= 1'b1;
                           state   <= ST_DROP;
                        end
                     end
                     OP_COMMIT: state  <= ST_COMMIT_WAIT;
                     OP_ABORT:  shadow <= cr_bus_o;
                     OP_NOP:    ;
                     default:   ;
                  endcase
               end
            end

            ST_DATA, ST_DROP: begin
               if (accept) begin
                  if (state == ST_DATA) begin
                     for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                        if (ptr == 3'(i)) shadow[i*8 +: 8] <= data_i;
                     end
                     ptr <= ptr + 3'd1;
                  end
                  remaining <= remaining - 4'd1;
                  to_cnt    <= '0;
                  if (remaining == 4'd1) state <= ST_IDLE;
               end else if (to_cnt == TIMEOUT_LIMIT) begin
                  // Stalled frame: keep bytes already staged, flag and leave
                  error_o <= 1'b1;
                  to_cnt  <= '0;
                  state   <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
            end

            ST_COMMIT_WAIT: begin
               if (!COMMIT_ON_STRB || sample_strb_i) begin
                  cr_bus_o     <= shadow;
                  cfg_update_o <= 1'b1;
                  state        <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fg_config_loader.sv
// tb_fg_config_loader
// Directed bench for fg_config_loader. Two instances share clock and reset:
// dut0 commits immediately (COMMIT_ON_STRB=0), dut1 waits for the strobe.
// Each has its own byte stream so their handshakes stay independent.
module tb_fg_config_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  data_s  [2];
   logic        valid_s [2];
   logic        strb_s  [2];
   logic        ready_s [2];
   logic [55:0] bus_s   [2];
   logic        upd_s   [2];
   logic        busy_s  [2];
   logic        err_s   [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fg_config_loader #(.COMMIT_ON_STRB(1'b0)) dut0 (
      .clk_i(clk), .rst_i(rst),
      .data_i(data_s[0]), .data_valid_i(valid_s[0]), .data_ready_o(ready_s[0]),
      .sample_strb_i(strb_s[0]), .cr_bus_o(bus_s[0]), .cfg_update_o(upd_s[0]),
      .busy_o(busy_s[0]), .error_o(err_s[0])
   );

   fg_config_loader #(.COMMIT_ON_STRB(1'b1)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .data_i(data_s[1]), .data_valid_i(valid_s[1]), .data_ready_o(ready_s[1]),
      .sample_strb_i(strb_s[1]), .cr_bus_o(bus_s[1]), .cfg_update_o(upd_s[1]),
      .busy_o(busy_s[1]), .error_o(err_s[1])
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one byte to instance s; returns #1 after the accepting edge
   task automatic send_byte(input int s, input logic [7:0] b);
      int n;
      n = 0;
      data_s[s]  = b;
      valid_s[s] = 1'b1;
      while (ready_s[s] !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      if (ready_s[s] !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_byte_timeout dut%0d: ready=%b required 1", s, ready_s[s]);
      end
      tick(1);
      valid_s[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      for (int s = 0; s < 2; s++) begin
         n_checks++;
         if (bus_s[s] !== 56'h0) begin n_fail++; $display("FAIL reset_bus dut%0d: got %h required 0", s, bus_s[s]); end
         n_checks++;
         if (ready_s[s] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b required 1", s, ready_s[s]); end
         n_checks++;
         if (busy_s[s] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b required 0", s, busy_s[s]); end
         n_checks++;
         if (err_s[s] !== 1'b0) begin n_fail++; $display("FAIL reset_error dut%0d: got %b required 0", s, err_s[s]); end
         n_checks++;
         if (upd_s[s] !== 1'b0) begin n_fail++; $display("FAIL reset_update dut%0d: got %b required 0", s, upd_s[s]); end
      end
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_full_load();
      send_byte(0, 8'h70);
      n_checks++;
      if (busy_s[0] !== 1'b1) begin n_fail++; $display("FAIL full_busy_hdr: got %b required 1", busy_s[0]); end
      for (int i = 1; i <= 7; i++) send_byte(0, 8'(i * 17));
      n_checks++;
      if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL full_idle_after_data: got %b required 0", busy_s[0]); end
      n_checks++;
      if (bus_s[0] !== 56'h0) begin n_fail++; $display("FAIL full_bus_before_commit: got %h required 0", bus_s[0]); end
      send_byte(0, 8'h80);
      n_checks++;
      if (ready_s[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_commit_wait: got %b required 0", ready_s[0]); end
      tick(1);
      n_checks++;
      if (bus_s[0] !== 56'h77665544332211) begin n_fail++; $display("FAIL full_bus: got %h required 77665544332211", bus_s[0]); end
      n_checks++;
      if (upd_s[0] !== 1'b1) begin n_fail++; $display("FAIL full_update_pulse: got %b required 1", upd_s[0]); end
      tick(1);
      n_checks++;
      if (upd_s[0] !== 1'b0) begin n_fail++; $display("FAIL full_update_width: got %b required 0", upd_s[0]); end
   endtask

   task automatic test_deferred();
      send_byte(1, 8'h42);
      send_byte(1, 8'hAB);
      send_byte(1, 8'h80);
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (ready_s[1] !== 1'b0 || bus_s[1] !== 56'h0) begin
            n_fail++;
            $display("FAIL deferred_hold cycle %0d: ready=%b bus=%h required ready 0 bus 0", i, ready_s[1], bus_s[1]);
         end
         tick(1);
      end
      strb_s[1] = 1'b1;
      tick(1);
      strb_s[1] = 1'b0;
      n_checks++;
      if (bus_s[1] !== 56'h00000000AB0000) begin n_fail++; $display("FAIL deferred_bus: got %h required 00000000ab0000", bus_s[1]); end
      n_checks++;
      if (upd_s[1] !== 1'b1 || ready_s[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL deferred_update: update=%b ready=%b required 1 1", upd_s[1], ready_s[1]);
      end
      // Strobe coincident with the COMMIT header edge must not commit
      send_byte(1, 8'h46);
      send_byte(1, 8'hCD);
      strb_s[1] = 1'b1;
      send_byte(1, 8'h80);
      strb_s[1] = 1'b0;
      tick(1);
      n_checks++;
      if (upd_s[1] !== 1'b0 || bus_s[1] !== 56'h00000000AB0000) begin
         n_fail++;
         $display("FAIL strb_coincident: update=%b bus=%h required 0 00000000ab0000", upd_s[1], bus_s[1]);
      end
      strb_s[1] = 1'b1;
      tick(1);
      strb_s[1] = 1'b0;
      n_checks++;
      if (bus_s[1] !== 56'hCD000000AB0000 || upd_s[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL strb_late_commit: bus=%h update=%b required cd000000ab0000 1", bus_s[1], upd_s[1]);
      end
   endtask

   task automatic test_bad_frame();
      send_byte(0, 8'h55);
      n_checks++;
      if (err_s[0] !== 1'b1 || busy_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_hdr: error=%b busy=%b required 1 1", err_s[0], busy_s[0]);
      end
      send_byte(0, 8'hE1);
      send_byte(0, 8'hE2);
      n_checks++;
      if (busy_s[0] !== 1'b1) begin n_fail++; $display("FAIL bad_still_dropping: got %b required 1", busy_s[0]); end
      send_byte(0, 8'hE3);
      n_checks++;
      if (busy_s[0] !== 1'b0 || err_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_consumed: busy=%b error=%b required 0 1", busy_s[0], err_s[0]);
      end
      send_byte(0, 8'h80);
      n_checks++;
      if (err_s[0] !== 1'b0) begin n_fail++; $display("FAIL bad_error_clear: got %b required 0", err_s[0]); end
      tick(1);
      n_checks++;
      if (bus_s[0] !== 56'h77665544332211 || upd_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_shadow_kept: bus=%h update=%b required 77665544332211 1", bus_s[0], upd_s[0]);
      end
   endtask

   task automatic test_abort();
      send_byte(0, 8'h40);
      send_byte(0, 8'hFF);
      send_byte(0, 8'hC0);
      n_checks++;
      if (busy_s[0] !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b required 0", busy_s[0]); end
      send_byte(0, 8'h80);
      tick(1);
      n_checks++;
      if (bus_s[0] !== 56'h77665544332211 || upd_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_restore: bus=%h update=%b required 77665544332211 1", bus_s[0], upd_s[0]);
      end
      tick(1);
      n_checks++;
      if (upd_s[0] !== 1'b0) begin n_fail++; $display("FAIL abort_single_pulse: got %b required 0", upd_s[0]); end
   endtask

   task automatic test_back_to_back();
      data_s[0]  = 8'h80;
      valid_s[0] = 1'b1;
      tick(1);
      n_checks++;
      if (ready_s[0] !== 1'b0 || upd_s[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_wait: ready=%b update=%b required 0 0", ready_s[0], upd_s[0]);
      end
      tick(1);
      n_checks++;
      if (upd_s[0] !== 1'b1 || ready_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_pulse: update=%b ready=%b required 1 1", upd_s[0], ready_s[0]);
      end
      tick(1);
      valid_s[0] = 1'b0;
      n_checks++;
      if (upd_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_gap: update=%b ready=%b required 0 0", upd_s[0], ready_s[0]);
      end
      tick(1);
      n_checks++;
      if (upd_s[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_second_pulse: got %b required 1", upd_s[0]); end
      tick(1);
   endtask

   task automatic test_timeout();
      send_byte(0, 8'h58);
      send_byte(0, 8'h99);
      tick(100);
      n_checks++;
      if (busy_s[0] !== 1'b1 || err_s[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: busy=%b error=%b required 1 0", busy_s[0], err_s[0]);
      end
      tick(200);
      n_checks++;
      if (busy_s[0] !== 1'b0 || err_s[0] !== 1'b1 || ready_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_expired: busy=%b error=%b ready=%b required 0 1 1", busy_s[0], err_s[0], ready_s[0]);
      end
      send_byte(0, 8'h80);
      n_checks++;
      if (err_s[0] !== 1'b0) begin n_fail++; $display("FAIL timeout_error_clear: got %b required 0", err_s[0]); end
      tick(1);
      n_checks++;
      if (bus_s[0] !== 56'h77665544332299) begin n_fail++; $display("FAIL timeout_partial_kept: got %h required 77665544332299", bus_s[0]); end
   endtask

   task automatic test_reset_mid_frame();
      send_byte(0, 8'h58);
      send_byte(0, 8'h12);
      send_byte(1, 8'h80);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_checks++;
      if (bus_s[0] !== 56'h0 || busy_s[0] !== 1'b0 || err_s[0] !== 1'b0 || ready_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_frame: bus=%h busy=%b error=%b ready=%b required 0 0 0 1", bus_s[0], busy_s[0], err_s[0], ready_s[0]);
      end
      n_checks++;
      if (bus_s[1] !== 56'h0 || busy_s[1] !== 1'b0 || ready_s[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_commit_wait: bus=%h busy=%b ready=%b required 0 0 1", bus_s[1], busy_s[1], ready_s[1]);
      end
      strb_s[1] = 1'b1;
      tick(1);
      strb_s[1] = 1'b0;
      n_checks++;
      if (upd_s[1] !== 1'b0 || bus_s[1] !== 56'h0) begin
         n_fail++;
         $display("FAIL rst_commit_lost: update=%b bus=%h required 0 0", upd_s[1], bus_s[1]);
      end
      send_byte(0, 8'h80);
      tick(1);
      n_checks++;
      if (bus_s[0] !== 56'h0 || upd_s[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_shadow_cleared: bus=%h update=%b required 0 1", bus_s[0], upd_s[0]);
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         data_s[s]  = 8'h00;
         valid_s[s] = 1'b0;
         strb_s[s]  = 1'b0;
      end
      test_reset();
      test_full_load();
      test_deferred();
      test_bad_frame();
      test_abort();
      test_back_to_back();
      test_timeout();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
